uart_frame_tx_arbiter: RTL and testbench
========================================

Name: uart_frame_tx_arbiter

Overview:
- Shares a single UART transmitter (byte interface: tx_data / tx_wr / tx_done) between two requesters, e.g. game logic and debug.
- Each requester submits one fixed-length payload. The block arbitrates round-robin and serialises a framed packet into the transmitter: header, source ID, payload bytes, checksum.
- It waits on tx_done for each byte and reports completion, or a timeout, back to the granted requester.
- Sits between the application logic and the uart_new transmit port.

Parameters:
- PAYLOAD_LEN, 4, payload bytes per frame (1..16).
- HEADER, 8'hAA, first byte of every frame.
- TIMEOUT, 0, max cycles to wait for tx_done per byte; 0 disables the watchdog.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 has a frame pending; held until ack0.
- data0  input  8*PAYLOAD_LEN  requester 0 payload; byte 0 = MSB byte.
- ack0  output  1  one-cycle pulse: data0 captured, req0 may drop.
- done0  output  1  one-cycle pulse: requester 0 frame fully transmitted.
- req1, data1, ack1, done1: same as above, for requester 1.
- err  output  1  one-cycle pulse: frame aborted on timeout.
- busy  output  1  high from grant until frame end or abort.
- tx_data  output  8  byte to transmitter.
- tx_wr  output  1  one-cycle write strobe to transmitter.
- tx_done  input  1  transmitter finished current byte (one-cycle pulse).

Behaviour:
- Reset values: ack0=ack1=done0=done1=err=busy=tx_wr=0; tx_data=8'h00; state=IDLE; round-robin pointer favours requester 0.
- States: IDLE -> GRANT -> SEND -> WAIT -> (SEND | FINISH) -> IDLE. Timeout exits WAIT to IDLE.
- IDLE:
  - Samples req0/req1 each edge.
  - If only one request is high, that requester is granted.
  - If both are high, the requester not served last is granted.
  - On grant: payload latched, source ID set (0 or 1), checksum accumulator cleared, go to GRANT.
  - Request seen at edge N: ackX high during cycle N+1, busy high from N+1.
- GRANT: ackX for exactly one cycle; round-robin pointer updated to the granted ID; then SEND.
- Byte order: HEADER, ID (8'h00/8'h01), payload byte 0..PAYLOAD_LEN-1, checksum. Total PAYLOAD_LEN+3 bytes.
- Checksum: 8-bit sum, mod 256, of the ID byte and all payload bytes. HEADER is excluded.
- SEND:
  - tx_wr=1 for one cycle with tx_data valid.
  - tx_data is held stable until the next SEND.
  - First tx_wr (header) occurs in cycle N+2.
- WAIT:
  - On tx_done, advance the byte index. If the last byte is done, go to FINISH; otherwise go to SEND in the next cycle. Minimum gap: tx_done at cycle M -> next tx_wr at M+1.
  - tx_done outside WAIT is ignored.
- FINISH: doneX pulses one cycle, busy drops in the same cycle; back to IDLE. A new grant can be made on the following edge.
- Timeout (TIMEOUT>0):
  - Cycle counter resets on each tx_wr.
  - If TIMEOUT cycles elapse in WAIT without tx_done: err pulses one cycle, no doneX, busy drops, return to IDLE.
  - The pointer keeps the aborted ID marked as served.
- Request rules:
  - If req drops before ack, no frame is sent for it.
  - reqX still high after doneX counts as a new request.
  - Requests arriving while busy wait; they are not queued beyond the level of req.
- Payload changes after ack do not affect the frame in flight.
- Reset mid-frame: immediate return to IDLE with reset values. tx_wr never pulses in the reset cycle; a partially sent frame is abandoned without done/err.
- Byte index width: clog2(PAYLOAD_LEN+3).

Test Plan:
- Single frame: PAYLOAD_LEN=4, req0, data0=32'h01020304, transmitter model returns tx_done 20 cycles after each tx_wr -> ack0 at N+1, tx_data sequence AA 00 01 02 03 04 0A, one done0, busy low afterwards.
- Checksum wrap: req1, data1=32'hFFFFFFFF -> bytes AA 01 FF FF FF FF FD, done1 only.
- Simultaneous requests after reset: req0 and req1 held high -> requester 0 frame first, then requester 1, then 0 again; grants strictly alternate and no byte interleaving occurs between frames.
- Handshake timing: tx_done one cycle after each tx_wr -> next tx_wr exactly one cycle after tx_done. A spurious tx_done injected in IDLE -> no state change.
- Timeout: TIMEOUT=50, transmitter never asserts tx_done -> err pulse 50 cycles after the header tx_wr, no done0, busy=0, next req1 served normally.
- Reset mid-frame: sys_rst asserted after the third byte's tx_wr -> all outputs at reset values next cycle; a fresh req0 then sends a complete frame starting with AA.

Source files
------------

// File: rtl/uart_frame_tx_arbiter.sv
// Round-robin arbiter that frames one payload per grant into a shared
// byte-wide UART transmitter: header, source id, payload, checksum.
module uart_frame_tx_arbiter #(
  parameter int         PAYLOAD_LEN = 4,
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         TIMEOUT     = 0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     req0,
  input  logic [8*PAYLOAD_LEN-1:0] data0,
  output logic                     ack0,
  output logic                     done0,
  input  logic                     req1,
  input  logic [8*PAYLOAD_LEN-1:0] data1,
  output logic                     ack1,
  output logic                     done1,
  output logic                     err,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_wr,
  input  logic                     tx_done
);

  localparam int NB = PAYLOAD_LEN + 3;
  localparam int IW = $clog2(NB);
  localparam int PW = 8 * PAYLOAD_LEN;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [TW-1:0] TO_LAST =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   load_idx;
  logic [PW-1:0]   pay;
  logic [7:0]      csum;
  logic [7:0]      tx_q;
  logic [7:0]      byte_sel;
  logic [TW-1:0]   cnt;
  logic            src;
  logic            last;
  logic            gnt_any;
  logic            gnt_id;
  logic            load_en;
  logic            last_byte;
  logic            timeout;
  logic            ld_hdr;
  logic            ld_id;
  logic            ld_sum;
  logic            run;

  assign run     = !sys_rst;
  assign gnt_any = req0 | req1;
  // With both pending, whoever was not served last wins.
  assign gnt_id  = (req0 & req1) ? ~last : req1;

  assign last_byte = (idx == LAST_IDX);
  assign timeout   = (TIMEOUT > 0) && (state == S_WAIT) &&
                     !tx_done && (cnt == TO_LAST);

  always_comb begin
    load_idx = (state == S_GRANT) ? '0 : idx + IW'(1);
    load_en  = (state == S_GRANT) ||
               ((state == S_WAIT) && tx_done && !last_byte);
    ld_hdr   = (load_idx == '0);
    ld_id    = (load_idx == IW'(1));
    ld_sum   = (load_idx == LAST_IDX);
    byte_sel = pay[PW-1 -: 8];
    unique case (1'b1)
      ld_hdr:  byte_sel = HEADER;
      ld_id:   byte_sel = {7'b0, src};
      ld_sum:  byte_sel = csum;
      default: byte_sel = pay[PW-1 -: 8];
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (gnt_any) state_n = S_GRANT;
      S_GRANT:  state_n = S_SEND;
      S_SEND:   state_n = S_WAIT;
      S_WAIT: begin
        if (tx_done)      state_n = last_byte ? S_FINISH : S_SEND;
        else if (timeout) state_n = S_IDLE;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
      idx   <= '0;
      pay   <= '0;
      csum  <= '0;
      tx_q  <= '0;
      cnt   <= '0;
      src   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      if ((state == S_IDLE) && gnt_any) begin
        src  <= gnt_id;
        pay  <= gnt_id ? data1 : data0;
        csum <= '0;
      end
      if (state == S_GRANT) last <= src;
      if (state == S_SEND)  cnt  <= '0;
      if (state == S_WAIT)  cnt  <= cnt + TW'(1);
      if (load_en) begin
        idx  <= load_idx;
        tx_q <= byte_sel;
        if (!ld_hdr && !ld_sum) csum <= csum + byte_sel;
        // Payload is consumed MSB byte first by shifting it up.
        if (!ld_hdr && !ld_id && !ld_sum) pay <= pay << 8;
      end
    end
  end

  assign ack0    = run && (state == S_GRANT) && !src;
  assign ack1    = run && (state == S_GRANT) && src;
  assign done0   = run && (state == S_FINISH) && !src;
  assign done1   = run && (state == S_FINISH) && src;
  assign err     = run && timeout;
  assign busy    = run && ((state == S_GRANT) ||
                           (state == S_SEND) ||
                           (state == S_WAIT));
  assign tx_wr   = run && (state == S_SEND);
  assign tx_data = tx_q;

endmodule

// File: tb/tb_uart_frame_tx_arbiter.sv
// Directed and randomized bench for uart_frame_tx_arbiter with a
// transmitter model and a frame-level reference model.
module tb_uart_frame_tx_arbiter;

  localparam int PL = 4;
  localparam int TO = 50;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [31:0]   data0 = '0;
  logic [31:0]   data1 = '0;
  logic          tx_done = 1'b0;
  logic          ack0, ack1, done0, done1, err, busy, tx_wr;
  logic [7:0]    tx_data;

  uart_frame_tx_arbiter #(
    .PAYLOAD_LEN(PL),
    .HEADER(8'hAA),
    .TIMEOUT(TO)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req0(req0),
    .data0(data0),
    .ack0(ack0),
    .done0(done0),
    .req1(req1),
    .data1(data1),
    .ack1(ack1),
    .done1(done1),
    .err(err),
    .busy(busy),
    .tx_data(tx_data),
    .tx_wr(tx_wr),
    .tx_done(tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Transmitter model: tx_done 'lat' cycles after each tx_wr.
  int lat = 20;
  bit tx_en = 1'b1;
  int cd = 0;
  int spur_req = 0;
  int spur_ack = 0;
  initial forever begin
    @(negedge sys_clk);
    tx_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) tx_done = 1'b1;
    end
    if (spur_req != spur_ack) begin
      tx_done  = 1'b1;
      spur_ack = spur_req;
    end
    if (tx_wr && tx_en) cd = lat;
  end

  // Event logs stamped with the cycle count.
  logic [7:0] txq[$];
  int txc[$];
  int ackc[$];
  int ackid[$];
  int donec[$];
  int doneid[$];
  int errc[$];
  int idle_wr = 0;
  initial forever begin
    @(negedge sys_clk);
    if (tx_wr) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
      if (!busy) idle_wr++;
    end
    if (ack0)  begin ackc.push_back(cyc);  ackid.push_back(0);  end
    if (ack1)  begin ackc.push_back(cyc);  ackid.push_back(1);  end
    if (done0) begin donec.push_back(cyc); doneid.push_back(0); end
    if (done1) begin donec.push_back(cyc); doneid.push_back(1); end
    if (err)   errc.push_back(cyc);
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exq[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clear_logs();
    txq.delete(); txc.delete();
    ackc.delete(); ackid.delete();
    donec.delete(); doneid.delete();
    errc.delete(); exq.delete();
  endtask

  // Reference frame: AA, id, payload MSB first, sum of id+payload mod 256.
  function automatic void add_frame(input int id, input logic [31:0] d);
    int sum;
    int b;
    sum = id;
    exq.push_back(8'hAA);
    exq.push_back(8'(id));
    for (int i = 0; i < PL; i++) begin
      b = int'((d >> (8 * (PL - 1 - i))) & 32'hFF);
      exq.push_back(8'(b));
      sum = (sum + b) % 256;
    end
    exq.push_back(8'(sum));
  endfunction

  task automatic wait_ends(input int n, input int budget);
    int k = 0;
    while ((donec.size() + errc.size() < n) && (k < budget)) begin
      tick();
      k++;
    end
    check("end_within_budget", 64'(donec.size() + errc.size() >= n), 1);
  endtask

  task automatic cmp_bytes(input string tag);
    check({tag, "_nbytes"}, txq.size(), exq.size());
    for (int i = 0; i < exq.size() && i < txq.size(); i++)
      check({tag, "_byte"}, txq[i], exq[i]);
  endtask

  task automatic do_frame(input int id, input logic [31:0] d,
                          input string tag);
    int c0;
    int k;
    clear_logs();
    add_frame(id, d);
    if (id == 0) begin data0 = d; req0 = 1'b1; end
    else         begin data1 = d; req1 = 1'b1; end
    c0 = cyc;
    k = 0;
    while (ackc.size() == 0 && k < 10) begin tick(); k++; end
    check({tag, "_busy_at_ack"}, busy, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_ends(1, 600);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_ack_cyc"}, (ackc.size() > 0) ? ackc[0] : -1, c0 + 1);
    check({tag, "_ack_id"}, (ackid.size() > 0) ? ackid[0] : -1, id);
    check({tag, "_hdr_cyc"}, (txc.size() > 0) ? txc[0] : -1, c0 + 2);
    cmp_bytes(tag);
    check({tag, "_ndone"}, donec.size(), 1);
    check({tag, "_done_id"}, (doneid.size() > 0) ? doneid[0] : -1, id);
    check({tag, "_nerr"}, errc.size(), 0);
    tick();
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] a2;
    logic [31:0] b;
    int c0;
    int k;
    int bad_gap;
    bit changed;

    // Reset state
    repeat (3) tick();
    check("rst_ack", {ack0, ack1}, 0);
    check("rst_done", {done0, done1}, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 8'h00);
    sys_rst = 1'b0;
    repeat (2) tick();

    // Both requesters held high: 0, 1, 0 with a fast transmitter
    lat = 1;
    clear_logs();
    a  = $urandom;
    a2 = $urandom;
    b  = $urandom;
    add_frame(0, a);
    add_frame(1, b);
    add_frame(0, a2);
    data0 = a; data1 = b;
    req0 = 1'b1; req1 = 1'b1;
    c0 = cyc;
    changed = 1'b0;
    k = 0;
    while (donec.size() < 3 && k < 300) begin
      tick();
      k++;
      if (ackc.size() >= 1 && !changed) begin
        data0 = a2;
        changed = 1'b1;
      end
      if (ackc.size() >= 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_first_ack_cyc", (ackc.size() > 0) ? ackc[0] : -1, c0 + 1);
    check("rr_nack", ackc.size(), 3);
    for (int i = 0; i < 3 && i < ackid.size(); i++)
      check("rr_ack_order", ackid[i], i % 2);
    check("rr_ndone", donec.size(), 3);
    for (int i = 0; i < 3 && i < doneid.size(); i++)
      check("rr_done_order", doneid[i], i % 2);
    cmp_bytes("rr");
    bad_gap = 0;
    for (int i = 1; i < txc.size(); i++)
      if ((i % (PL + 3)) != 0 && txc[i] - txc[i-1] != 2) bad_gap++;
    check("rr_min_gap", bad_gap, 0);
    check("rr_wr_outside_busy", idle_wr, 0);
    repeat (3) tick();

    // Spurious tx_done while idle
    clear_logs();
    spur_req++;
    repeat (5) tick();
    check("spur_busy", busy, 0);
    check("spur_no_wr", txq.size(), 0);
    check("spur_no_ack", ackc.size(), 0);

    // Directed single frames
    lat = 20;
    do_frame(0, 32'h01020304, "single");
    do_frame(1, 32'hFFFFFFFF, "wrap");

    // Watchdog abort, then pointer must favour requester 1
    tx_en = 1'b0;
    clear_logs();
    data0 = $urandom;
    req0 = 1'b1;
    k = 0;
    while (ackc.size() == 0 && k < 10) begin tick(); k++; end
    req0 = 1'b0;
    wait_ends(1, 200);
    check("to_nerr", errc.size(), 1);
    check("to_err_cyc", (errc.size() > 0) ? errc[0] : -1,
          (txc.size() > 0) ? txc[0] + TO : -1);
    check("to_nbytes", txq.size(), 1);
    check("to_ndone", donec.size(), 0);
    tick();
    check("to_busy_after", busy, 0);
    tx_en = 1'b1;
    lat = 3;
    clear_logs();
    b = $urandom;
    add_frame(1, b);
    data0 = $urandom; data1 = b;
    req0 = 1'b1; req1 = 1'b1;
    k = 0;
    while (ackc.size() == 0 && k < 10) begin tick(); k++; end
    req0 = 1'b0; req1 = 1'b0;
    wait_ends(1, 200);
    check("to_next_ack_id", (ackid.size() > 0) ? ackid[0] : -1, 1);
    check("to_next_done_id", (doneid.size() > 0) ? doneid[0] : -1, 1);
    cmp_bytes("to_next");
    repeat (2) tick();

    // Reset in the middle of a frame
    lat = 5;
    clear_logs();
    data0 = $urandom;
    req0 = 1'b1;
    k = 0;
    while (txq.size() < 3 && k < 100) begin
      tick();
      k++;
      if (ackc.size() > 0) req0 = 1'b0;
    end
    req0 = 1'b0;
    check("mid_three_bytes", txq.size(), 3);
    sys_rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_wr", tx_wr, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_pulses", {ack0, ack1, done0, done1, err}, 0);
    sys_rst = 1'b0;
    repeat (12) tick();
    check("mid_no_done_err", donec.size() + errc.size(), 0);
    check("mid_no_more_bytes", txq.size(), 3);
    do_frame(0, $urandom, "after_rst");

    // Randomized frames
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 12);
      do_frame($urandom_range(0, 1), $urandom, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
